// File: rtl/prob_unit_arbiter_pkg.sv
// Shared types for the prob_computer arbiter: FSM state encoding, data width,
// and the downhill test that decides whether a move can skip the unit.
package prob_unit_arbiter_pkg;

    localparam int DATA_W = 32;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_RESP,
        ST_RECOVER
    } state_t;

    // Equal costs count as downhill so they take the free accept path.
    function automatic logic is_downhill(input logic [DATA_W-1:0] cost_new,
                                         input logic [DATA_W-1:0] cost_old);
        return cost_new <= cost_old;
    endfunction

endpackage

// File: rtl/prob_unit_arbiter_rr.sv
// Combinational round-robin picker: first set request searching cyclically
// from ptr+1, returned both one-hot and as an index.
module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int IW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic [NREQ-1:0] grant,
    output logic [IW-1:0]   idx,
    output logic            any
);

    // NOTE: every output gets a default before the search so no latch is inferred.
    always_comb begin
        int cand;
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        cand  = 0;
        for (int off = 1; off <= NREQ; off++) begin
            cand = (int'(ptr) + off) % NREQ;
            if (!any && req[cand]) begin
                any         = 1'b1;
                grant[cand] = 1'b1;
                idx         = IW'(cand);
            end
        end
    end

endmodule

// File: rtl/prob_unit_arbiter.sv
// Shares one single-op prob_computer among NREQ annealing workers: round-robin
// grant, downhill fast path, timeout with recovery, and usage statistics.
module prob_unit_arbiter
    import prob_unit_arbiter_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 256
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NREQ-1:0]          req_valid,
    output logic [NREQ-1:0]          req_ready,
    input  logic [DATA_W*NREQ-1:0]   req_new,
    input  logic [DATA_W*NREQ-1:0]   req_old,
    input  logic [DATA_W*NREQ-1:0]   req_rand,
    input  logic [DATA_W-1:0]        tinv,
    output logic [NREQ-1:0]          resp_valid,
    output logic                     resp_accept,
    output logic [DATA_W-1:0]        pc_new,
    output logic [DATA_W-1:0]        pc_old,
    output logic [DATA_W-1:0]        pc_tinv,
    output logic                     pc_inp_valid,
    input  logic [DATA_W-1:0]        pc_out,
    input  logic                     pc_out_valid,
    output logic                     err_timeout,
    output logic [31:0]              stat_ops,
    output logic [31:0]              stat_acc
);

    localparam int IW = $clog2(NREQ);
    localparam int TW = $clog2(TIMEOUT);

    state_t              state;
    logic [IW-1:0]       ptr;
    logic [IW-1:0]       cur_idx;
    logic [DATA_W-1:0]   cur_rand;
    logic [TW-1:0]       timer;
    logic                timed_out;
    logic [DATA_W-1:0]   pc_res;
    logic                pc_res_valid;

    logic [NREQ-1:0]     arb_grant;
    logic [IW-1:0]       arb_idx;
    logic                arb_any;
    logic                transfer;
    logic                timer_done;
    logic [NREQ-1:0]     cur_onehot;
    logic [DATA_W-1:0]   sel_new;
    logic [DATA_W-1:0]   sel_old;
    logic [DATA_W-1:0]   sel_rand;

    rr_arbiter #(.NREQ(NREQ), .IW(IW)) u_rr (
        .req   (req_valid),
        .ptr   (ptr),
        .grant (arb_grant),
        .idx   (arb_idx),
        .any   (arb_any)
    );

    assign req_ready  = (state == ST_IDLE) ? arb_grant : '0;
    assign transfer   = (state == ST_IDLE) && arb_any;
    assign timer_done = (timer == TW'(TIMEOUT - 1));
    assign cur_onehot = {{(NREQ-1){1'b0}}, 1'b1} << cur_idx;
    assign sel_new    = req_new[DATA_W*int'(arb_idx) +: DATA_W];
    assign sel_old    = req_old[DATA_W*int'(arb_idx) +: DATA_W];
    assign sel_rand   = req_rand[DATA_W*int'(arb_idx) +: DATA_W];

    // The unit result is registered before comparison, adding one cycle of latency.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_IDLE;
            ptr          <= IW'(NREQ - 1);
            cur_idx      <= '0;
            cur_rand     <= '0;
            timer        <= '0;
            timed_out    <= 1'b0;
            pc_res       <= '0;
            pc_res_valid <= 1'b0;
            resp_valid   <= '0;
            resp_accept  <= 1'b0;
            pc_new       <= '0;
            pc_old       <= '0;
            pc_tinv      <= '0;
            pc_inp_valid <= 1'b0;
            err_timeout  <= 1'b0;
            stat_ops     <= '0;
            stat_acc     <= '0;
        end else begin
            // NOTE: non-blocking throughout; these defaults make the strobes one-cycle pulses.
            pc_res       <= pc_out;
            pc_res_valid <= pc_out_valid;
            pc_inp_valid <= 1'b0;
            resp_valid   <= '0;
            resp_accept  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (transfer) begin
                        ptr       <= arb_idx;
                        cur_idx   <= arb_idx;
                        cur_rand  <= sel_rand;
                        timed_out <= 1'b0;
                        if (is_downhill(sel_new, sel_old)) begin
                            resp_valid  <= arb_grant;
                            resp_accept <= 1'b1;
                            stat_acc    <= stat_acc + 32'd1;
                            state       <= ST_RESP;
                        end else begin
                            pc_new       <= sel_new;
                            pc_old       <= sel_old;
                            pc_tinv      <= tinv;
                            pc_inp_valid <= 1'b1;
                            state        <= ST_ISSUE;
                        end
                    end
                end
                ST_ISSUE: begin
                    stat_ops <= stat_ops + 32'd1;
                    timer    <= '0;
                    state    <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (pc_res_valid) begin
                        resp_valid  <= cur_onehot;
                        resp_accept <= (pc_res > cur_rand);
                        stat_acc    <= stat_acc + {31'd0, (pc_res > cur_rand)};
                        state       <= ST_RESP;
                    end else if (timer_done) begin
                        resp_valid  <= cur_onehot;
                        err_timeout <= 1'b1;
                        timed_out   <= 1'b1;
                        state       <= ST_RESP;
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                ST_RESP: begin
                    timer <= '0;
                    state <= timed_out ? ST_RECOVER : ST_IDLE;
                end
                ST_RECOVER: begin
                    // A late result only proves the unit is free again; its value is dropped.
                    if (pc_res_valid || timer_done) begin
                        state <= ST_IDLE;
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_prob_unit_arbiter.sv
// Directed bench for prob_unit_arbiter with a behavioural prob_computer model
// whose answer value and latency are set per test.
module tb_prob_unit_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  req_valid = '0;
    logic [3:0]  req_ready;
    logic [31:0] t_new [4];
    logic [31:0] t_old [4];
    logic [31:0] t_rand [4];
    logic [127:0] req_new, req_old, req_rand;
    logic [31:0] tinv = 32'h3F80_0000;
    logic [3:0]  resp_valid;
    logic        resp_accept;
    logic [31:0] pc_new, pc_old, pc_tinv;
    logic        pc_inp_valid;
    logic [31:0] pc_out = '0;
    logic        pc_out_valid = 1'b0;
    logic        err_timeout;
    logic [31:0] stat_ops, stat_acc;

    int checks = 0;
    int failures = 0;

    // Unit model controls and bench-side monitors.
    logic        model_on = 1'b0;
    int          model_lat = 1;
    logic [31:0] model_out = '0;
    int          pend = 0;
    int          late_req_cnt = 0;
    int          late_done_cnt = 0;
    int          issue_cnt = 0;
    int          overlap_n = 0;
    logic        in_flight = 1'b0;
    int          grant_log [64];
    int          grant_n = 0;

    assign req_new  = {t_new[3],  t_new[2],  t_new[1],  t_new[0]};
    assign req_old  = {t_old[3],  t_old[2],  t_old[1],  t_old[0]};
    assign req_rand = {t_rand[3], t_rand[2], t_rand[1], t_rand[0]};

    prob_unit_arbiter #(.NREQ(4), .TIMEOUT(256)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_new      (req_new),
        .req_old      (req_old),
        .req_rand     (req_rand),
        .tinv         (tinv),
        .resp_valid   (resp_valid),
        .resp_accept  (resp_accept),
        .pc_new       (pc_new),
        .pc_old       (pc_old),
        .pc_tinv      (pc_tinv),
        .pc_inp_valid (pc_inp_valid),
        .pc_out       (pc_out),
        .pc_out_valid (pc_out_valid),
        .err_timeout  (err_timeout),
        .stat_ops     (stat_ops),
        .stat_acc     (stat_acc)
    );

    always #5 clk = ~clk;

    function automatic int onehot_idx(input logic [3:0] v);
        int r = 99;
        for (int i = 0; i < 4; i++) if (v[i]) r = i;
        return r;
    endfunction

    // prob_computer model: answers model_lat negedges after it sees the issue strobe.
    always @(negedge clk) begin
        pc_out_valid <= 1'b0;
        if (rst) begin
            pend <= 0;
        end else if (late_req_cnt != late_done_cnt) begin
            pc_out_valid  <= 1'b1;
            pc_out        <= 32'h00FF_0000;
            late_done_cnt <= late_done_cnt + 1;
        end else if (pend == 1) begin
            pc_out_valid <= 1'b1;
            pc_out       <= model_out;
            pend         <= 0;
        end else if (pend > 1) begin
            pend <= pend - 1;
        end
        if (pc_inp_valid && model_on && !rst) pend <= model_lat;
    end

    always @(posedge clk) begin
        if (rst) begin
            in_flight <= 1'b0;
        end else begin
            if (|(req_valid & req_ready)) begin
                grant_log[grant_n % 64] <= onehot_idx(req_valid & req_ready);
                grant_n <= grant_n + 1;
            end
            if (pc_inp_valid) issue_cnt <= issue_cnt + 1;
            if (pc_inp_valid && in_flight) overlap_n <= overlap_n + 1;
            if (pc_inp_valid) in_flight <= 1'b1;
            else if (|resp_valid) in_flight <= 1'b0;
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [31:0] nv, input logic [31:0] ov,
                           input logic [31:0] rv);
        t_new[i]  = nv;
        t_old[i]  = ov;
        t_rand[i] = rv;
    endtask

    // Entered at the negedge of the transfer cycle; drops requests, then waits for a response.
    task automatic wait_resp(input string tag, input logic [3:0] exp_vec, input logic exp_acc,
                             input int max_cyc, output int lat);
        step();
        req_valid = '0;
        @(negedge clk);
        lat = 1;
        while (resp_valid == '0 && lat < max_cyc) begin
            @(negedge clk);
            lat++;
        end
        check({tag, "_resp_vec"}, 64'(resp_valid), 64'(exp_vec));
        check({tag, "_accept"}, 64'(resp_accept), 64'(exp_acc));
    endtask

    initial begin
        int lat;
        int n;
        int k;
        int g0;
        logic [3:0]   ready_seen;
        logic [127:0] out_or;
        int exp_order [5] = '{0, 1, 2, 3, 0};

        for (int i = 0; i < 4; i++) set_req(i, 32'd0, 32'd0, 32'd0);

        // 1: reset, idle for 10 cycles with everything at zero
        repeat (3) step();
        rst = 1'b0;
        out_or = '0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            out_or |= {64'(req_ready | resp_valid), 32'(stat_ops | stat_acc),
                       pc_new | pc_old | pc_tinv | {29'd0, resp_accept, pc_inp_valid, err_timeout}};
        end
        check("t1_idle_outputs", 64'(out_or[127:64] | out_or[63:0]), 64'd0);

        // 2: downhill fast path for W0
        step();
        set_req(0, 32'd100, 32'd150, 32'd0);
        req_valid = 4'b0001;
        @(negedge clk);
        check("t2_grant", 64'(req_ready), 64'h1);
        wait_resp("t2", 4'b0001, 1'b1, 10, lat);
        check("t2_latency", 64'(lat), 64'd1);
        check("t2_stat_acc", 64'(stat_acc), 64'd1);
        @(negedge clk);
        check("t2_no_issue", 64'(issue_cnt), 64'd0);

        // 3: uphill moves through the unit, one accept and one reject
        model_on  = 1'b1;
        model_lat = 2;
        model_out = 32'h00C0_0000;
        step();
        set_req(1, 32'd200, 32'd100, 32'h00A0_0000);
        req_valid = 4'b0010;
        @(negedge clk);
        check("t3a_grant", 64'(req_ready), 64'h2);
        wait_resp("t3a", 4'b0010, 1'b1, 30, lat);
        check("t3a_latency", 64'(lat), 64'd5);
        check("t3_pc_new", 64'(pc_new), 64'd200);
        check("t3_pc_old", 64'(pc_old), 64'd100);
        check("t3_pc_tinv", 64'(pc_tinv), 64'h3F80_0000);
        step();
        set_req(1, 32'd200, 32'd100, 32'h00E0_0000);
        req_valid = 4'b0010;
        @(negedge clk);
        check("t3b_grant", 64'(req_ready), 64'h2);
        wait_resp("t3b", 4'b0010, 1'b0, 30, lat);
        check("t3_issue_pulses", 64'(issue_cnt), 64'd2);
        check("t3_stat_ops", 64'(stat_ops), 64'd2);
        check("t3_stat_acc", 64'(stat_acc), 64'd2);

        // 4: all four workers uphill continuously, pointer restarted by reset
        step();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        model_lat = 1;
        for (int i = 0; i < 4; i++) set_req(i, 32'd500, 32'd400, 32'h00A0_0000);
        g0 = grant_n;
        req_valid = 4'b1111;
        n = 0;
        k = 0;
        while (n < 5 && k < 200) begin
            @(negedge clk);
            if (|resp_valid) n++;
            k++;
        end
        step();
        req_valid = '0;
        repeat (3) @(negedge clk);
        check("t4_resp_count", 64'(n), 64'd5);
        check("t4_grant_count", 64'(grant_n - g0), 64'd5);
        for (int i = 0; i < 5; i++)
            check($sformatf("t4_grant_order_%0d", i), 64'(grant_log[(g0 + i) % 64]), 64'(exp_order[i]));
        check("t4_overlap", 64'(overlap_n), 64'd0);
        check("t4_stat_ops", 64'(stat_ops), 64'd5);
        check("t4_stat_acc", 64'(stat_acc), 64'd5);

        // 5: unit never answers -> timeout reject, recovery, late result discarded
        model_on = 1'b0;
        step();
        set_req(2, 32'd300, 32'd200, 32'd0);
        req_valid = 4'b0100;
        @(negedge clk);
        check("t5_grant", 64'(req_ready), 64'h4);
        wait_resp("t5", 4'b0100, 1'b0, 300, lat);
        check("t5_latency", 64'(lat), 64'd258);
        check("t5_err_timeout", 64'(err_timeout), 64'd1);
        step();
        set_req(3, 32'd600, 32'd500, 32'h00E0_0000);
        req_valid = 4'b1000;
        model_on  = 1'b1;
        model_lat = 2;
        model_out = 32'h00C0_0000;
        ready_seen = '0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            ready_seen |= req_ready;
            step();
        end
        check("t5_no_grant_recover", 64'(ready_seen), 64'd0);
        late_req_cnt++;
        n = 0;
        @(negedge clk);
        while (req_ready == '0 && n < 10) begin
            @(negedge clk);
            n++;
        end
        check("t5_grant_after_recover", 64'(req_ready), 64'h8);
        check("t5_recover_exit_cycles", 64'(n), 64'd2);
        wait_resp("t5_next", 4'b1000, 1'b0, 30, lat);
        check("t5_next_latency", 64'(lat), 64'd5);
        check("t5_err_sticky", 64'(err_timeout), 64'd1);
        check("t5_stat_ops", 64'(stat_ops), 64'd7);
        check("t5_stat_acc", 64'(stat_acc), 64'd5);

        // 6: reset while waiting on the unit drops the op silently
        model_on = 1'b0;
        step();
        set_req(0, 32'd900, 32'd800, 32'd0);
        req_valid = 4'b0001;
        @(negedge clk);
        check("t6_grant", 64'(req_ready), 64'h1);
        step();
        req_valid = '0;
        repeat (3) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        @(negedge clk);
        check("t6_ready", 64'(req_ready), 64'd0);
        check("t6_outputs", 64'({resp_valid, resp_accept, pc_inp_valid, err_timeout}), 64'd0);
        check("t6_stats", 64'({stat_ops, stat_acc}), 64'd0);
        check("t6_operands", 64'(pc_new | pc_old | pc_tinv), 64'd0);
        n = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (|resp_valid) n++;
        end
        check("t6_no_resp", 64'(n), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
